seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Time-multiplexing driver for the 4-digit seven-segment display; it is the producer of the active-low anode select and the per-digit nibble that the segment decoder consumes.
- Accepts a 16-bit display word (4 nibbles) over a valid/ready handshake.
- Double-buffers the word and commits it only at frame boundaries, so no tearing.
- Scans digits 0..3, inserting a blanking gap between digits to suppress ghosting.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (BLANK + ON); 1 kHz/digit at 100 MHz
BLANK_CYCLES, 1000, cycles per slot with all anodes off; legal range 1 <= BLANK_CYCLES < REFRESH_DIV

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; 0 forces display dark
digit_en  input  4  per-digit enable, bit i gates digit i
data_in  input  16  display word; nibble i = data_in[4i+3:4i] shown on digit i
data_valid  input  1  data_in offered
data_ready  output  1  buffer can accept a word
anode  output  4  active-low digit select: digit0=1110, 1=1101, 2=1011, 3=0111, off=1111
digit_val  output  4  nibble for the currently selected digit, to the decoder
frame_tick  output  1  one-cycle pulse at end of digit 3 slot

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: anode=1111, digit_val=0, frame_tick=0, data_ready=1. Internally: active word=0, pending flag=0, digit index=0, state=IDLE, timer=0.
- States:
  - IDLE: anode=1111, timer held at 0, index held at 0.
  - BLANK: anode=1111 for BLANK_CYCLES cycles.
  - ON: anode=one-hot-low(index) for REFRESH_DIV-BLANK_CYCLES cycles.
- Transitions:
  - IDLE -> BLANK(index 0) on the first cycle en=1.
  - BLANK -> ON when the timer expires.
  - ON -> BLANK(index+1) when the timer expires. After index 3, index wraps to 0.
  - Any state -> IDLE on the cycle after en=0; timer and index are cleared.
- Slot length: exactly REFRESH_DIV cycles. Frame length: exactly 4*REFRESH_DIV cycles.
- digit_val:
  - Updates to nibble(index) on the cycle BLANK is entered. It is stable for the whole slot.
  - In IDLE it holds nibble 0.
- Disabled digit (digit_en[index]=0): ON-phase anode stays 1111; slot timing is unchanged.
  - digit_en is sampled every cycle, so a change takes effect on the next cycle.
- Handshake:
  - data_ready = !pending.
  - Transfer happens when data_valid && data_ready. It captures data_in into the shadow buffer and sets pending; data_ready drops the following cycle.
  - data_valid without ready is ignored and nothing is captured. The source must hold the word.
- Commit:
  - On the last ON cycle of digit 3 (frame end): frame_tick pulses for one cycle.
  - If pending, the shadow is copied to the active word and pending clears. data_ready returns to 1 on the next cycle.
  - In IDLE, a pending word commits on the cycle after capture.
  - The new word is first visible as digit_val in the next digit-0 BLANK.
- Simultaneous events:
  - Capture and commit cannot collide, because capture requires !pending.
  - en falling on the frame-end cycle: frame_tick and the commit still occur, then the block enters IDLE.
- Reset mid-scan: immediate return to reset values. Any pending word is discarded.
- Width rules: timer is clog2(REFRESH_DIV) bits; the index is 2 bits and wraps naturally.

Decomposition:
- Shared package:
  - ANODE_OFF=4'b1111
  - anode lookup function index->one-hot-low
  - state enum {IDLE, BLANK, ON}
  - NUM_DIGITS=4
- Sub-module phase_timer: a loadable down-counter with an expire flag.
  - Loaded with BLANK_CYCLES-1 or REFRESH_DIV-BLANK_CYCLES-1.
  - Cleared in IDLE.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, en=1, digit_en=1111, data 0x4321 accepted in IDLE → first frame shows anode: 1111 ×2, 1110 ×6, 1111 ×2, 1101 ×6, …; digit_val = 1,2,3,4 per slot; frame_tick on cycle 32 of the scan.
2. Mid-frame word 0xABCD while 0x4321 active → data_ready=0 until frame end; digit 2 and 3 still show 3,4; next frame shows D,C,B,A; frame_tick coincides with data_ready rising the next cycle.
3. Second data_valid while pending → ignored; after commit, the held word transfers only when data_ready=1.
4. digit_en=1010 → digits 0 and 2 never drive low (anode stays 1111 for their full 8-cycle slots); digits 1 and 3 show normal 1101/0111 windows; frame length remains 32 cycles.
5. en dropped during digit 2 ON → next cycle anode=1111, digit_val=nibble 0; on re-enable, scan restarts at digit 0 BLANK.
6. rst_n asserted mid-ON with a word pending → anode=1111, data_ready=1, digit_val=0 immediately (asynchronously); after release, the display shows 0000.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and helpers for the 4-digit seven-segment scanner.
package seven_seg_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_e;

  function automatic logic [3:0] anode_of(input logic [1:0] idx);
    anode_of = ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] idx);
    nibble_of = word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seven_seg_scanner_phase_timer.sv
// Loadable down-counter; expired_o flags the final cycle of the loaded phase.
module seven_seg_scanner_phase_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o,
  output logic             expire_next_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o     = (count_q == '0);
  // Lets the caller register a flag that lines up with the final cycle itself.
  assign expire_next_o = (count_d == '0);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit anode/nibble scanner with blanking gaps and a
// double-buffered display word that commits only at frame boundaries.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  digit_en,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [3:0]  anode,
  output logic [3:0]  digit_val,
  output logic        frame_tick
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] ON_LOAD    = TW'(REFRESH_DIV - BLANK_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        tmr_clear, tmr_load, tmr_expired, tmr_expire_next;
  logic [TW-1:0] tmr_load_val;

  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;
  logic        pending_q, pending_d;
  logic        data_ready_q;
  logic [3:0]  anode_q, anode_d;
  logic [3:0]  digit_val_q, digit_val_d;
  logic        frame_tick_q, frame_tick_d;
  logic        frame_end, capture, commit;

  seven_seg_scanner_phase_timer #(.WIDTH(TW)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (tmr_clear),
    .load_i       (tmr_load),
    .load_val_i   (tmr_load_val),
    .expired_o    (tmr_expired),
    .expire_next_o(tmr_expire_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_clear    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = BLANK_LOAD;
    if (!en) begin
      state_d   = IDLE;
      idx_d     = 2'd0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
        end
        BLANK: begin
          if (tmr_expired) begin
            state_d      = ON;
            tmr_load     = 1'b1;
            tmr_load_val = ON_LOAD;
          end
        end
        ON: begin
          if (tmr_expired) begin
            state_d  = BLANK;
            idx_d    = idx_q + 2'd1;
            tmr_load = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          idx_d     = 2'd0;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  // Frame end is independent of en so a final-cycle disable still commits.
  assign frame_end = (state_q == ON) && (idx_q == 2'(NUM_DIGITS - 1)) && tmr_expired;
  assign capture   = data_valid && data_ready_q;
  assign commit    = pending_q && (frame_end || (state_q == IDLE));

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (capture) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end else if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    anode_d      = ANODE_OFF;
    digit_val_d  = digit_val_q;
    frame_tick_d = (state_d == ON) && (idx_d == 2'(NUM_DIGITS - 1)) && tmr_expire_next;
    if ((state_d == ON) && digit_en[idx_d]) begin
      anode_d = anode_of(idx_d);
    end
    if (state_d == IDLE) begin
      digit_val_d = nibble_of(active_d, 2'd0);
    end else if ((state_d == BLANK) && (state_q != BLANK)) begin
      digit_val_d = nibble_of(active_d, idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= 16'h0000;
      active_q     <= 16'h0000;
      pending_q    <= 1'b0;
      data_ready_q <= 1'b1;
      anode_q      <= ANODE_OFF;
      digit_val_q  <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      data_ready_q <= !pending_d;
      anode_q      <= anode_d;
      digit_val_q  <= digit_val_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign data_ready = data_ready_q;
  assign anode      = anode_q;
  assign digit_val  = digit_val_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with an 8-cycle slot
// (2 blank + 6 on), so a frame is 32 cycles.
module tb_seven_seg_scanner;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  digit_en;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  anode;
  logic [3:0]  digit_val;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .digit_en  (digit_en),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .anode     (anode),
    .digit_val (digit_val),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance through frame cycles c0..c1 (1-based) and check every output.
  task automatic scan(input string name, input logic [15:0] word, input logic [3:0] den,
                      input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      int slot;
      int pos;
      logic [15:0] sh;
      logic [3:0] exp_an;
      step();
      slot = (c - 1) / RD;
      pos  = (c - 1) % RD;
      sh   = word >> (4 * slot);
      exp_an = 4'b1111;
      if (pos >= BC && den[slot]) exp_an = ~(4'b0001 << slot);
      chk($sformatf("%s c%0d anode", name, c), {12'h0, anode}, {12'h0, exp_an});
      chk($sformatf("%s c%0d digit_val", name, c), {12'h0, digit_val}, {12'h0, sh[3:0]});
      chk($sformatf("%s c%0d frame_tick", name, c), {15'h0, frame_tick}, {15'h0, (c == 4 * RD)});
      $display("%s cycle %0d anode=%b digit_val=%h frame_tick=%b ready=%b",
               name, c, anode, digit_val, frame_tick, data_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; digit_en = 4'b1111; data_in = 16'h0; data_valid = 1'b0;
    step(); step();
    chk("reset anode", {12'h0, anode}, 16'h000F);
    chk("reset digit_val", {12'h0, digit_val}, 16'h0000);
    chk("reset frame_tick", {15'h0, frame_tick}, 16'h0000);
    chk("reset data_ready", {15'h0, data_ready}, 16'h0001);
    rst_n = 1'b1;

    // Scenario 1: word accepted in IDLE commits immediately, then scan starts.
    data_in = 16'h4321; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("idle capture ready", {15'h0, data_ready}, 16'h0000);
    step();
    chk("idle commit ready", {15'h0, data_ready}, 16'h0001);
    chk("idle digit_val", {12'h0, digit_val}, 16'h0001);
    en = 1'b1;
    scan("f1", 16'h4321, 4'b1111, 1, 32);

    // Scenarios 2/3: mid-frame word, then a second word held while pending.
    scan("f2", 16'h4321, 4'b1111, 1, 12);
    data_in = 16'hABCD; data_valid = 1'b1;
    scan("f2", 16'h4321, 4'b1111, 13, 13);
    data_valid = 1'b0;
    chk("f2 pending ready", {15'h0, data_ready}, 16'h0000);
    scan("f2", 16'h4321, 4'b1111, 14, 19);
    data_in = 16'h5678; data_valid = 1'b1;
    scan("f2", 16'h4321, 4'b1111, 20, 32);
    chk("f2 end ready", {15'h0, data_ready}, 16'h0000);
    scan("f3", 16'hABCD, 4'b1111, 1, 1);
    chk("f3 ready rises", {15'h0, data_ready}, 16'h0001);
    scan("f3", 16'hABCD, 4'b1111, 2, 2);
    data_valid = 1'b0;
    chk("f3 held word taken", {15'h0, data_ready}, 16'h0000);
    scan("f3", 16'hABCD, 4'b1111, 3, 32);
    scan("f4", 16'h5678, 4'b1111, 1, 1);
    chk("f4 ready", {15'h0, data_ready}, 16'h0001);
    scan("f4", 16'h5678, 4'b1111, 2, 32);

    // Scenario 4: digits 0 and 2 disabled, slot timing unchanged.
    digit_en = 4'b1010;
    scan("f5", 16'h5678, 4'b1010, 1, 32);
    digit_en = 4'b1111;

    // Scenario 5: disable during digit 2 ON, then restart.
    scan("f6", 16'h5678, 4'b1111, 1, 20);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("dis%0d anode", i), {12'h0, anode}, 16'h000F);
      chk($sformatf("dis%0d digit_val", i), {12'h0, digit_val}, 16'h0008);
      chk($sformatf("dis%0d frame_tick", i), {15'h0, frame_tick}, 16'h0000);
      $display("disabled cycle %0d anode=%b digit_val=%h", i, anode, digit_val);
    end
    en = 1'b1;
    scan("f7", 16'h5678, 4'b1111, 1, 32);

    // Scenario 6: asynchronous reset mid-ON with a word pending.
    scan("f8", 16'h5678, 4'b1111, 1, 4);
    data_in = 16'h9999; data_valid = 1'b1;
    scan("f8", 16'h5678, 4'b1111, 5, 5);
    data_valid = 1'b0;
    chk("f8 pending ready", {15'h0, data_ready}, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("async rst anode", {12'h0, anode}, 16'h000F);
    chk("async rst ready", {15'h0, data_ready}, 16'h0001);
    chk("async rst digit_val", {12'h0, digit_val}, 16'h0000);
    $display("async reset anode=%b ready=%b digit_val=%h", anode, data_ready, digit_val);
    step(); step();
    rst_n = 1'b1;
    scan("f9", 16'h0000, 4'b1111, 1, 32);
    chk("f9 ready", {15'h0, data_ready}, 16'h0001);
    scan("f10", 16'h0000, 4'b1111, 1, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
